// File: rtl/lutram_test_pkg.sv
// Shared definitions for the LUTRAM primitive tests: checker FSM encoding and
// the written test pattern (each entry holds its own address bit 0).
package lutram_test_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        DRAIN   = 2'b10,
        VERDICT = 2'b11
    } chk_state_e;

    // Written pattern: every location holds the LSB of its address.
    function automatic logic exp_pattern(input logic addr_lsb);
        return addr_lsb;
    endfunction

endpackage

// File: rtl/lutram_readback_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/lutram_readback_checker.sv
// Read-back checker for a dual-port LUTRAM sweep; registered PASS/FAIL verdict.
// Define CHECK_DPO_EN to include the DPO port in the mismatch check.
module lutram_readback_checker
    import lutram_test_pkg::*;
#(
    parameter int A_WIDTH   = 7,
    parameter int ERR_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 rd_valid_i,
    input  logic [A_WIDTH-1:0]   rd_addr_i,
    input  logic                 spo_i,
    input  logic                 dpo_i,
    input  logic                 done_i,
    output logic                 busy_o,
    output logic                 pass_o,
    output logic                 fail_o,
    output logic [ERR_WIDTH-1:0] err_count_o,
    output logic [A_WIDTH:0]     checked_o,
    output logic [A_WIDTH-1:0]   first_fail_addr_o
);

    localparam int STAGES = 1;
    localparam logic [A_WIDTH:0] FULL = {1'b1, {A_WIDTH{1'b0}}};

    chk_state_e         state;
    logic               exp_bit;
    logic               mis_c;
    logic               accept;
    logic [STAGES:1]    vld_pipe;
    logic [A_WIDTH-1:0] pipe_addr;
    logic               pipe_mis;
    logic               verdict_ok;

    always_comb begin
        exp_bit = exp_pattern(rd_addr_i[0]);
`ifdef CHECK_DPO_EN
        mis_c   = (spo_i != exp_bit) | (dpo_i != exp_bit);
`else
        mis_c   = (spo_i != exp_bit);
`endif
    end

`ifndef CHECK_DPO_EN
    logic dpo_unused;
    assign dpo_unused = dpo_i;
`endif

    // A restart takes priority over a sample arriving in the same cycle.
    assign accept = rd_valid_i && (state == ARMED) && !start_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe  <= '0;
            pipe_addr <= '0;
            pipe_mis  <= 1'b0;
        end else begin
            vld_pipe[1] <= accept;
            if (accept) begin
                pipe_addr <= rd_addr_i;
                pipe_mis  <= mis_c;
            end
        end
    end

    sat_counter #(.WIDTH(ERR_WIDTH)) u_err_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (start_i),
        .inc   (vld_pipe[STAGES] && pipe_mis),
        .count (err_count_o)
    );

    sat_counter #(.WIDTH(A_WIDTH + 1)) u_chk_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (start_i),
        .inc   (vld_pipe[STAGES]),
        .count (checked_o)
    );

    // The error counter never returns to zero once incremented, so zero means "no mismatch yet".
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            first_fail_addr_o <= '0;
        else if (start_i)
            first_fail_addr_o <= '0;
        else if (vld_pipe[STAGES] && pipe_mis && (err_count_o == '0))
            first_fail_addr_o <= pipe_addr;
    end

    assign verdict_ok = (err_count_o == '0) && (checked_o == FULL);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            pass_o <= 1'b0;
            fail_o <= 1'b0;
        end else if (start_i) begin
            state  <= ARMED;
            busy_o <= 1'b1;
            pass_o <= 1'b0;
            fail_o <= 1'b0;
        end else begin
            case (state)
                ARMED:   if (done_i) state <= DRAIN;
                DRAIN:   state <= VERDICT;
                VERDICT: begin
                    pass_o <= verdict_ok;
                    fail_o <= !verdict_ok;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lutram_readback_checker.sv
// Self-checking bench: vector table, hand-written timing sequences and random sweeps vs a model.
module tb_lutram_readback_checker;

    localparam int AW = 7;
    localparam int M_CLEAN = 0, M_SPO = 1, M_DPO = 2, M_SHORT = 3, M_INV = 4, M_DUP = 5;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, rd_valid = 1'b0;
    logic spo = 1'b0, dpo = 1'b0, done = 1'b0;
    logic [AW-1:0] addr = '0;

    logic          busy, pass, fail, busy4, pass4, fail4;
    logic [7:0]    errc;
    logic [3:0]    errc4;
    logic [AW:0]   chk, chk4;
    logic [AW-1:0] ffa, ffa4;

    int n_checks = 0;
    int n_fail   = 0;

    int q_addr[$];
    bit q_spo[$];
    bit q_dpo[$];

    typedef struct {
        string name;
        int    mode;
        int    arg;
        bit    done_last;
        bit    e_pass;
        int    e_err;
        int    e_err4;
        int    e_chk;
        int    e_ffa;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    lutram_readback_checker #(.A_WIDTH(AW), .ERR_WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .rd_valid_i(rd_valid),
        .rd_addr_i(addr), .spo_i(spo), .dpo_i(dpo), .done_i(done),
        .busy_o(busy), .pass_o(pass), .fail_o(fail), .err_count_o(errc),
        .checked_o(chk), .first_fail_addr_o(ffa)
    );

    lutram_readback_checker #(.A_WIDTH(AW), .ERR_WIDTH(4)) dut_s (
        .clk_i(clk), .rst_i(rst), .start_i(start), .rd_valid_i(rd_valid),
        .rd_addr_i(addr), .spo_i(spo), .dpo_i(dpo), .done_i(done),
        .busy_o(busy4), .pass_o(pass4), .fail_o(fail4), .err_count_o(errc4),
        .checked_o(chk4), .first_fail_addr_o(ffa4)
    );

    task automatic chk_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic build(input int mode, input int arg);
        int n;
        bit e;
        q_addr.delete(); q_spo.delete(); q_dpo.delete();
        n = (mode == M_SHORT) ? arg : (mode == M_DUP) ? 128 + arg : 128;
        for (int i = 0; i < n; i++) begin
            e = ((i % 128) % 2) == 1;
            q_addr.push_back(i % 128);
            q_spo.push_back(e ^ (mode == M_INV));
            q_dpo.push_back(e ^ (mode == M_INV));
        end
        if (mode == M_SPO) q_spo[arg] = ~q_spo[arg];
        if (mode == M_DPO) q_dpo[arg] = ~q_dpo[arg];
    endtask

    task automatic feed(input bit done_last);
        for (int i = 0; i < q_addr.size(); i++) begin
            rd_valid = 1'b1;
            addr     = AW'(q_addr[i]);
            spo      = q_spo[i];
            dpo      = q_dpo[i];
            done     = done_last && (i == q_addr.size() - 1);
            tick();
        end
        rd_valid = 1'b0;
        done     = 1'b0;
    endtask

    task automatic wait_verdict(input string nm);
        int k = 0;
        while (!(pass || fail) && k < 10) begin
            tick();
            k++;
        end
        chk_eq({nm, " verdict_seen"}, 32'(pass || fail), 1);
    endtask

    task automatic run_seq(input string nm, input bit done_last);
        pulse_start();
        feed(done_last);
        if (!done_last) begin
            done = 1'b1;
            tick();
            done = 1'b0;
        end
        wait_verdict(nm);
    endtask

    // Reference: outcome of a sweep from the written-pattern rule alone.
    task automatic model(output int m_chk, output int m_err, output int m_err4,
                         output int m_ffa, output bit m_pass);
        int  mis = 0;
        bit  seen = 0;
        bit  e, m;
        m_ffa = 0;
        for (int i = 0; i < q_addr.size(); i++) begin
            e = (q_addr[i] % 2) == 1;
            m = (q_spo[i] != e);
`ifdef CHECK_DPO_EN
            m = m || (q_dpo[i] != e);
`endif
            if (m) begin
                if (!seen) m_ffa = q_addr[i];
                seen = 1;
                mis++;
            end
        end
        m_chk  = (q_addr.size() > 255) ? 255 : q_addr.size();
        m_err  = (mis > 255) ? 255 : mis;
        m_err4 = (mis > 15) ? 15 : mis;
        m_pass = (mis == 0) && (m_chk == 128);
    endtask

    task automatic check_outcome(input string nm, input bit e_pass, input int e_err,
                                 input int e_err4, input int e_chk, input int e_ffa);
        chk_eq({nm, " pass"}, 32'(pass), 32'(e_pass));
        chk_eq({nm, " fail"}, 32'(fail), 32'(!e_pass));
        chk_eq({nm, " busy"}, 32'(busy), 0);
        chk_eq({nm, " err"}, 32'(errc), e_err);
        chk_eq({nm, " err4"}, 32'(errc4), e_err4);
        chk_eq({nm, " fail4"}, 32'(fail4), 32'(!e_pass));
        chk_eq({nm, " checked"}, 32'(chk), e_chk);
        chk_eq({nm, " first_addr"}, 32'(ffa), e_ffa);
    endtask

    task automatic check_all_zero(input string nm);
        chk_eq({nm, " busy"}, 32'(busy), 0);
        chk_eq({nm, " pass"}, 32'(pass), 0);
        chk_eq({nm, " fail"}, 32'(fail), 0);
        chk_eq({nm, " err"}, 32'(errc), 0);
        chk_eq({nm, " checked"}, 32'(chk), 0);
        chk_eq({nm, " first_addr"}, 32'(ffa), 0);
        chk_eq({nm, " busy4"}, 32'(busy4), 0);
        chk_eq({nm, " checked4"}, 32'(chk4), 0);
        chk_eq({nm, " first_addr4"}, 32'(ffa4), 0);
    endtask

    task automatic add_vec(input string name, input int mode, input int arg, input bit dl,
                           input bit ep, input int ee, input int ee4, input int ec, input int ef);
        vec_t v;
        v.name = name; v.mode = mode; v.arg = arg; v.done_last = dl;
        v.e_pass = ep; v.e_err = ee; v.e_err4 = ee4; v.e_chk = ec; v.e_ffa = ef;
        tbl.push_back(v);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int m_chk, m_err, m_err4, m_ffa;
        bit m_pass;

        add_vec("clean",     M_CLEAN, 0,   1, 1, 0,   0,  128, 0);
        add_vec("spo_flip",  M_SPO,   37,  0, 0, 1,   1,  128, 37);
`ifdef CHECK_DPO_EN
        add_vec("dpo_flip",  M_DPO,   5,   1, 0, 1,   1,  128, 5);
`else
        add_vec("dpo_flip",  M_DPO,   5,   1, 1, 0,   0,  128, 0);
`endif
        add_vec("short",     M_SHORT, 100, 0, 0, 0,   0,  100, 0);
        add_vec("saturate",  M_INV,   0,   1, 0, 128, 15, 128, 0);
        add_vec("duplicate", M_DUP,   1,   0, 0, 0,   0,  129, 0);

        #1 rst = 1'b1;
        tick(); tick();
        check_all_zero("reset");
        #2 rst = 1'b0;
        tick();

        // done_i while idle has no effect
        done = 1'b1; tick(); done = 1'b0; tick(); tick(); tick();
        chk_eq("idle_done busy", 32'(busy), 0);
        chk_eq("idle_done verdict", 32'(pass || fail), 0);

        foreach (tbl[i]) begin
            build(tbl[i].mode, tbl[i].arg);
            run_seq(tbl[i].name, tbl[i].done_last);
            check_outcome(tbl[i].name, tbl[i].e_pass, tbl[i].e_err, tbl[i].e_err4,
                          tbl[i].e_chk, tbl[i].e_ffa);
        end

        // Latency: counters two edges after the sample, verdict three cycles after done_i.
        pulse_start();
        chk_eq("lat busy_after_start", 32'(busy), 1);
        chk_eq("lat verdict_cleared", 32'(pass || fail), 0);
        rd_valid = 1'b1; addr = 7'd3; spo = 1'b0; dpo = 1'b1;
        tick();
        rd_valid = 1'b0;
        chk_eq("lat checked_stage1", 32'(chk), 0);
        tick();
        chk_eq("lat checked_stage2", 32'(chk), 1);
        chk_eq("lat err_stage2", 32'(errc), 1);
        chk_eq("lat first_addr", 32'(ffa), 3);
        rd_valid = 1'b1; addr = 7'd8; spo = 1'b1; dpo = 1'b0;
        tick();
        rd_valid = 1'b0;
        tick();
        chk_eq("lat err_second", 32'(errc), 2);
        chk_eq("lat first_addr_held", 32'(ffa), 3);
        done = 1'b1;
        tick();
        done = 1'b0;
        chk_eq("lat verdict_d1", 32'(pass || fail), 0);
        tick();
        chk_eq("lat verdict_d2", 32'(pass || fail), 0);
        chk_eq("lat busy_d2", 32'(busy), 1);
        tick();
        chk_eq("lat fail_d3", 32'(fail), 1);
        chk_eq("lat pass_d3", 32'(pass), 0);
        chk_eq("lat busy_d3", 32'(busy), 0);

        // Samples in IDLE are ignored and the verdict is sticky.
        rd_valid = 1'b1; addr = 7'd0; spo = 1'b0; dpo = 1'b0; done = 1'b1;
        tick(); tick(); tick();
        rd_valid = 1'b0; done = 1'b0;
        chk_eq("idle checked_held", 32'(chk), 2);
        chk_eq("idle fail_held", 32'(fail), 1);

        // Restart while armed flushes the pipeline and clears counters.
        build(M_INV, 0);
        q_addr = q_addr[0:59]; q_spo = q_spo[0:59]; q_dpo = q_dpo[0:59];
        pulse_start();
        feed(0);
        pulse_start();
        chk_eq("restart err_cleared", 32'(errc), 0);
        tick();
        chk_eq("restart err_flushed", 32'(errc), 0);
        chk_eq("restart checked_flushed", 32'(chk), 0);
        build(M_CLEAN, 0);
        feed(1);
        wait_verdict("restart");
        check_outcome("restart", 1, 0, 0, 128, 0);

        // Asynchronous reset mid-sweep.
        build(M_SPO, 37);
        q_addr = q_addr[0:49]; q_spo = q_spo[0:49]; q_dpo = q_dpo[0:49];
        pulse_start();
        feed(0);
        chk_eq("midreset busy_before", 32'(busy), 1);
        chk_eq("midreset err_before", 32'(errc), 1);
        #3 rst = 1'b1;
        #1 check_all_zero("midreset");
        #2 rst = 1'b0;
        tick();
        build(M_CLEAN, 0);
        run_seq("after_reset", 1);
        check_outcome("after_reset", 1, 0, 0, 128, 0);

        // Random sweeps against the reference model.
        for (int t = 0; t < 12; t++) begin
            int n;
            bit e;
            n = (t % 3 == 0) ? 128 : $urandom_range(118, 134);
            q_addr.delete(); q_spo.delete(); q_dpo.delete();
            for (int i = 0; i < n; i++) begin
                q_addr.push_back((t % 4 == 1) ? $urandom_range(0, 127) : (i % 128));
                e = (q_addr[i] % 2) == 1;
                q_spo.push_back(e ^ ((t % 3 != 0) && ($urandom_range(0, 39) == 0)));
                q_dpo.push_back(e ^ ((t % 3 != 0) && ($urandom_range(0, 39) == 0)));
            end
            model(m_chk, m_err, m_err4, m_ffa, m_pass);
            run_seq($sformatf("rand%0d", t), bit'($urandom_range(0, 1)));
            check_outcome($sformatf("rand%0d", t), m_pass, m_err, m_err4, m_chk, m_ffa);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
